// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instruction_fetch_unit_pkg;

    // Next-PC source select driven by decode.
    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_J   = 2'b10,
        PCSRC_JR  = 2'b11
    } pcsrc_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/instruction_fetch_unit_fetch_next_pc.sv
// Next-PC calculation: sequential, branch, jump and jump-register targets.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is used (stall).
//
// Ports:
//   i_pcf       current fetch PC
//   i_pcplus4d  PC+4 of the instruction in decode (base for branch/jump)
//   i_pcsrc     next-PC select
//   i_bimm      signed word offset for branches
//   i_jidx      jump target index
//   i_jreg      jump-register target
//   o_seq_pc    i_pcf + 4
//   o_next_pc   target selected by i_pcsrc
//   o_misalign  jump-register selected with a non word-aligned target
module fetch_next_pc
    import instruction_fetch_unit_pkg::*;
(
    input  logic [31:0] i_pcf,
    input  logic [31:0] i_pcplus4d,
    input  logic [1:0]  i_pcsrc,
    input  logic [15:0] i_bimm,
    input  logic [25:0] i_jidx,
    input  logic [31:0] i_jreg,
    output logic [31:0] o_seq_pc,
    output logic [31:0] o_next_pc,
    output logic        o_misalign
);

    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_jr_target;

    // 32-bit modulo arithmetic: 0xFFFF_FFFC + 4 wraps to 0.
    assign o_seq_pc    = i_pcf + 32'd4;
    assign w_br_target = i_pcplus4d + {{14{i_bimm[15]}}, i_bimm, 2'b00};
    assign w_j_target  = {i_pcplus4d[31:28], i_jidx, 2'b00};
    // Low bits are forced to zero; the misalignment is reported separately.
    assign w_jr_target = {i_jreg[31:2], 2'b00};

    always_comb begin
        o_next_pc = o_seq_pc;
        case (pcsrc_e'(i_pcsrc))
            PCSRC_SEQ: o_next_pc = o_seq_pc;
            PCSRC_BR:  o_next_pc = w_br_target;
            PCSRC_J:   o_next_pc = w_j_target;
            PCSRC_JR:  o_next_pc = w_jr_target;
            default:   o_next_pc = o_seq_pc;
        endcase
    end

    assign o_misalign = (pcsrc_e'(i_pcsrc) == PCSRC_JR) && (i_jreg[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, instruction-memory addressing, IF/ID register.
// Latency: instruction at PCF in cycle n appears in InstrD in cycle n+1; redirects cost one bubble.
// Backpressure: Stall freezes PC and IF/ID (Flush during Stall still squashes IF/ID).
//
// Ports:
//   CLK, Reset         clock, synchronous active-high reset
//   Stall, Flush       hazard controls from decode
//   PCSrc              next-PC select (seq / branch / jump / jump-register)
//   BranchImm, JumpIdx, JumpReg   redirect target sources
//   ImemAddr, ImemRD   combinational instruction-memory port
//   PCF                current fetch PC
//   InstrD, PCPlus4D, ValidD      IF/ID register
//   MisalignErr        sticky misaligned jump-register flag
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          IMEM_AW  = 6
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Stall,
    input  logic               Flush,
    input  logic [1:0]         PCSrc,
    input  logic [15:0]        BranchImm,
    input  logic [25:0]        JumpIdx,
    input  logic [31:0]        JumpReg,
    output logic [IMEM_AW-1:0] ImemAddr,
    input  logic [31:0]        ImemRD,
    output logic [31:0]        PCF,
    output logic [31:0]        InstrD,
    output logic [31:0]        PCPlus4D,
    output logic               ValidD,
    output logic               MisalignErr
);

    logic [31:0] r_pcf;
    ifid_t       r_ifid;
    logic        r_misalign_err;

    logic [31:0] w_seq_pc;
    logic [31:0] w_next_pc;
    logic        w_misalign;
    logic        w_redirect;

    fetch_next_pc u_next_pc (
        .i_pcf      (r_pcf),
        .i_pcplus4d (r_ifid.pc_plus4),
        .i_pcsrc    (PCSrc),
        .i_bimm     (BranchImm),
        .i_jidx     (JumpIdx),
        .i_jreg     (JumpReg),
        .o_seq_pc   (w_seq_pc),
        .o_next_pc  (w_next_pc),
        .o_misalign (w_misalign)
    );

    // Only meaningful when not stalled; the stall branch below takes priority.
    assign w_redirect = (pcsrc_e'(PCSrc) != PCSRC_SEQ);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_pcf          <= RESET_PC;
            r_ifid         <= IFID_BUBBLE;
            r_misalign_err <= 1'b0;
        end else if (Stall) begin
            // Decode is held too and will re-present any redirect request,
            // so PCSrc is ignored here. Flush still squashes the held slot.
            if (Flush) begin
                r_ifid.instr <= NOP_INSTR;
                r_ifid.valid <= 1'b0;
            end
        end else if (w_redirect) begin
            // No delay slot: the word fetched this cycle is wrong-path.
            r_pcf  <= w_next_pc;
            r_ifid <= IFID_BUBBLE;
            if (w_misalign) begin
                r_misalign_err <= 1'b1;
            end
        end else if (Flush) begin
            r_pcf  <= w_seq_pc;
            r_ifid <= IFID_BUBBLE;
        end else begin
            r_pcf           <= w_seq_pc;
            r_ifid.instr    <= ImemRD;
            r_ifid.pc_plus4 <= w_seq_pc;
            r_ifid.valid    <= 1'b1;
        end
    end

    // Word address; PCs beyond the memory wrap by truncation.
    assign ImemAddr    = r_pcf[IMEM_AW+1:2];
    assign PCF         = r_pcf;
    assign InstrD      = r_ifid.instr;
    assign PCPlus4D    = r_ifid.pc_plus4;
    assign ValidD      = r_ifid.valid;
    assign MisalignErr = r_misalign_err;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage feeding the 64-entry, 32-bit combinational instruction memory. Holds the program counter, drives the word address into the memory, captures the returned instruction into the IF/ID pipeline register, and computes the next PC from sequential, branch, jump and jump-register sources. Stall, flush and redirect requests come from the decode/hazard logic.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `IMEM_AW`, default `6`: instruction-memory word-address width.
- `CLK`, in, 1: rising-edge clock.
- `Reset`, in, 1: synchronous, active-high.
- `Stall`, in, 1: hold the PC and IF/ID.
- `Flush`, in, 1: squash the IF/ID contents.
- `PCSrc`, in, 2: next-PC select. 00 sequential, 01 branch, 10 jump, 11 jump-register.
- `BranchImm`, in, 16: branch offset in words, signed.
- `JumpIdx`, in, 26: jump target index.
- `JumpReg`, in, 32: jump-register target.
- `ImemAddr`, out, `IMEM_AW`: word address to the instruction memory.
- `ImemRD`, in, 32: instruction word from memory, same cycle.
- `PCF`, out, 32: current fetch PC (byte address).
- `InstrD`, out, 32: IF/ID instruction.
- `PCPlus4D`, out, 32: IF/ID PC+4.
- `ValidD`, out, 1: IF/ID holds a real instruction.
- `MisalignErr`, out, 1: sticky flag for a misaligned jump-register target.

## Operation
- **Addressing.** `ImemAddr = PCF[IMEM_AW+1:2]`.
  - Addresses at or beyond 64 words wrap by truncation.
  - PC arithmetic is 32-bit modulo: `32'hFFFF_FFFC + 4 = 0`.
- **Targets.** All are relative to the instruction in decode:
  - Branch: `PCPlus4D + {{14{BranchImm[15]}}, BranchImm, 2'b00}`.
  - Jump: `{PCPlus4D[31:28], JumpIdx, 2'b00}`.
  - Jump-register: `{JumpReg[31:2], 2'b00}`. If `JumpReg[1:0] != 0`, `MisalignErr` sets and stays set until `Reset`.
- **Redirect.** `PCSrc != 00` while not stalled is a redirect. There is no delay slot: the instruction fetched in the redirect cycle is wrong-path and is squashed.
- **Per-edge priority, highest first:**
  1. `Reset`: `PCF = RESET_PC`, `InstrD = 0`, `PCPlus4D = 0`, `ValidD = 0`, `MisalignErr = 0`.
  2. `Stall`: `PCF` holds. `PCSrc` is ignored; decode is also held, so it re-presents the request.
     - IF/ID holds, unless `Flush` is also asserted, in which case `InstrD = 0` and `ValidD = 0`.
  3. Redirect: `PCF` takes the target. IF/ID loads a bubble (`InstrD = 0`, `ValidD = 0`, `PCPlus4D = 0`).
  4. `Flush`: IF/ID loads a bubble; `PCF` advances to `PCF + 4`.
  5. Normal: `PCF` advances to `PCF + 4`; IF/ID captures `InstrD = ImemRD`, `PCPlus4D = PCF + 4`, `ValidD = 1`.
- `InstrD = 0` is the NOP encoding.

## Timing
- Memory read is combinational, so the instruction at `PCF` is presented in the same cycle.
- Latency: `PCF` in cycle n gives `InstrD` / `ValidD = 1` in cycle n+1.
- First edge after `Reset` deasserts captures the word at `RESET_PC`. `ValidD` is 0 during the reset cycle and the cycle after.
- Redirect penalty is one bubble cycle. The target instruction appears in IF/ID two edges after the redirect request.
- `Stall` held for k cycles freezes all registers for k edges. Throughput resumes at 1 instruction per cycle after release.
- `Reset` mid-stall or mid-redirect overrides everything on that edge.
- All outputs are registered except `ImemAddr`, which is a slice of `PCF`.

## Structure
- Shared package holds:
  - `PCSRC_SEQ`, `PCSRC_BR`, `PCSRC_J`, `PCSRC_JR` (2-bit encodings).
  - `NOP_INSTR = 32'h0000_0000`.
  - Default `RESET_PC`.
- One combinational sub-module, `fetch_next_pc`. It computes the sequential, branch, jump and jump-register targets and the misalignment flag from `PCF`, `PCPlus4D`, `PCSrc`, `BranchImm`, `JumpIdx` and `JumpReg`.
- The top level holds the PC register, the IF/ID register, the sticky error flag and the priority logic.

## Test plan
- **Reset then sequential fetch.** Memory words 0..3 = `32'h1111_1111` .. `32'h4444_4444`. Release reset, no stall or redirect.
  - `PCF` = 0, 4, 8, 12 on successive cycles.
  - `InstrD` = `1111_1111`, `2222_2222`, … one cycle later, with `ValidD = 1` and `PCPlus4D` = 4, 8, 12, ….
- **Branch.** `PCSrc = 01`, `BranchImm = 16'hFFFE`, `PCPlus4D = 32'h10`.
  - Next `PCF = 32'h8`.
  - IF/ID bubble for one cycle, then `InstrD` = word 2.
- **Jump and jump-register.**
  - `PCSrc = 10`, `JumpIdx = 26'h5`, `PCPlus4D = 0`: `PCF = 32'h14`.
  - `PCSrc = 11`, `JumpReg = 32'h22`: `PCF = 32'h20`, `MisalignErr = 1` and it stays 1 until reset.
- **Stall and flush.**
  - `Stall` for 3 cycles: `PCF` and IF/ID frozen for 3 cycles.
  - `Stall` with `PCSrc = 10`: no redirect.
  - `Stall` with `Flush`: `ValidD = 0`, `PCF` unchanged.
- **Wrap-around.**
  - `RESET_PC = 32'hFC`: `ImemAddr = 63`, next `ImemAddr = 0` with `PCF = 32'h100`.
  - `RESET_PC = 32'hFFFF_FFFC`: next `PCF = 0`.
- **Reset mid-operation.** Assert `Reset` during a redirect with `Stall = 1`.
  - Next edge: `PCF = RESET_PC`, `ValidD = 0`, `MisalignErr = 0`.
